sensor_qualifier: RTL and testbench

- Conditions the raw photo-sensor pin before lag measurement: synchronises it to `clock`, applies polarity, and debounces it.
- Produces a single-cycle `hit` pulse on the first qualified dark-to-light transition after each `arm`.
- Sits directly upstream of the measurement/min-max logic. `arm` is the start-of-test flag already crossed into the `clock` domain; `hit` replaces the raw rising-edge detect.
- Also reports a `timeout` when no light edge arrives within a bounded window.

---
 rtl/sensor_qualifier.sv | 190 +++++++++++++++++++
 tb/tb_sensor_qualifier.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_qualifier.sv
`default_nettype none
// ============================================================================
// Module      : sensor_qualifier
// Description : Conditions the raw photo-sensor pin for lag measurement.
//               The pin is synchronised into the clock domain, corrected for
//               polarity and debounced. A small FSM then emits a single-cycle
//               hit on the first clean dark-to-light transition after each
//               arm, or a single-cycle timeout if the armed window expires.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   1  system clock (27 MHz nominal)
//   reset        in   1  asynchronous, active-high reset
//   SENSOR       in   1  raw sensor pin, asynchronous to clock
//   arm          in   1  single-cycle pulse, starts/restarts a measurement
//   hit          out  1  single-cycle pulse on a qualified light edge
//   timeout      out  1  single-cycle pulse when the armed window expires
//   waiting      out  1  high while a measurement is in progress
//   sensor_level out  1  debounced light level (1 = light)
//   hit_count    out  8  hits since reset, wraps 255 -> 0
// ============================================================================
module sensor_qualifier #(
    parameter int STABLE_CYCLES  = 27,
    parameter int TIMEOUT_CYCLES = 13500000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       SENSOR,
    input  logic       arm,
    output logic       hit,
    output logic       timeout,
    output logic       waiting,
    output logic       sensor_level,
    output logic [7:0] hit_count
);

    localparam logic [15:0] c_dc_last = 16'(STABLE_CYCLES - 1);
    localparam logic [23:0] c_tc_last = 24'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DARK = 2'd1,
        ARMED     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser and polarity correction
    // ------------------------------------------------------------------
    logic r_s1;
    logic r_s2;
    logic w_lv;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= SENSOR;
            r_s2 <= r_s1;
        end
    end

    assign w_lv = r_s2 ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Debounce: the filtered level follows w_lv only after it has held
    // the opposite value for STABLE_CYCLES consecutive cycles. Any return
    // to the current level clears the run count.
    // ------------------------------------------------------------------
    logic [15:0] r_dc;
    logic        r_level;
    logic        r_level_prev;
    logic        w_rise;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dc    <= '0;
            r_level <= 1'b0;
        end else if (w_lv == r_level) begin
            r_dc <= '0;
        end else if (r_dc == c_dc_last) begin
            r_level <= w_lv;
            r_dc    <= '0;
        end else begin
            r_dc <= r_dc + 16'd1;
        end
    end

    // Previous filtered level, for dark-to-light edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_level_prev <= 1'b0;
        end else begin
            r_level_prev <= r_level;
        end
    end

    assign w_rise = r_level & ~r_level_prev;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_tc;
    logic [23:0] w_tc_next;
    logic        w_hit_next;
    logic        w_timeout_next;
    logic        r_hit;
    logic        r_timeout;
    logic        r_waiting;
    logic [7:0]  r_hit_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tc        <= '0;
            r_hit       <= 1'b0;
            r_timeout   <= 1'b0;
            r_waiting   <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tc      <= w_tc_next;
            r_hit     <= w_hit_next;
            r_timeout <= w_timeout_next;
            // waiting is registered alongside the state so it drops in the
            // same cycle the hit or timeout pulse appears
            r_waiting <= (w_state_next != IDLE);
            if (w_hit_next) begin
                r_hit_count <= r_hit_count + 8'd1;
            end
        end
    end

    // arm overrides everything; within a measurement a hit beats a
    // coincident timeout.
    always_comb begin
        w_state_next   = r_state;
        w_tc_next      = r_tc;
        w_hit_next     = 1'b0;
        w_timeout_next = 1'b0;
        if (arm) begin
            w_state_next = WAIT_DARK;
            w_tc_next    = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = IDLE;
                end
                WAIT_DARK: begin
                    // A screen that is already light must go dark first,
                    // otherwise a stale light level would count as a hit.
                    if (r_tc == c_tc_last) begin
                        w_timeout_next = 1'b1;
                        w_state_next   = IDLE;
                    end else begin
                        w_tc_next = r_tc + 24'd1;
                        if (!r_level) begin
                            w_state_next = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (w_rise) begin
                        w_hit_next   = 1'b1;
                        w_state_next = IDLE;
                    end else if (r_tc == c_tc_last) begin
                        w_timeout_next = 1'b1;
                        w_state_next   = IDLE;
                    end else begin
                        w_tc_next = r_tc + 24'd1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    assign hit          = r_hit;
    assign timeout      = r_timeout;
    assign waiting      = r_waiting;
    assign sensor_level = r_level;
    assign hit_count    = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_sensor_qualifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_qualifier
// Description : Directed self-checking bench for sensor_qualifier with
//               STABLE_CYCLES=4, TIMEOUT_CYCLES=100, ACTIVE_LOW=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_qualifier;

    logic       clock = 1'b0;
    logic       reset;
    logic       SENSOR;
    logic       arm;
    logic       hit;
    logic       timeout;
    logic       waiting;
    logic       sensor_level;
    logic [7:0] hit_count;

    int checks = 0;
    int errors = 0;

    sensor_qualifier #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(100),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .SENSOR      (SENSOR),
        .arm         (arm),
        .hit         (hit),
        .timeout     (timeout),
        .waiting     (waiting),
        .sensor_level(sensor_level),
        .hit_count   (hit_count)
    );

    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step(1);
        arm = 1'b0;
    endtask

    logic seen;

    initial begin
        reset  = 1'b1;
        SENSOR = 1'b1;   // dark with active-low sensor
        arm    = 1'b0;
        step(2);
        check("rst_hit", hit, 0);
        check("rst_timeout", timeout, 0);
        check("rst_waiting", waiting, 0);
        check("rst_level", sensor_level, 0);
        check("rst_count", hit_count, 0);
        reset = 1'b0;
        step(10);
        check("idle_level", sensor_level, 0);

        // ---- basic hit: 7 edges after first edge sampling low ----
        pulse_arm();
        check("t1_waiting", waiting, 1);
        step(10);
        SENSOR = 1'b0;
        step(6);
        check("t1_hit_early", hit, 0);
        check("t1_level", sensor_level, 1);
        step(1);
        check("t1_hit", hit, 1);
        check("t1_waiting_fall", waiting, 0);
        check("t1_count", hit_count, 1);
        step(1);
        check("t1_hit_single", hit, 0);

        // ---- glitch of 3 cycles is rejected, 4 cycles accepted ----
        SENSOR = 1'b1;
        step(10);
        check("t2_dark", sensor_level, 0);
        pulse_arm();
        step(3);
        SENSOR = 1'b0;
        step(3);
        SENSOR = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            seen = seen | sensor_level | hit;
        end
        check("t2_glitch_rejected", seen, 0);
        SENSOR = 1'b0;
        step(4);
        SENSOR = 1'b1;
        step(2);
        check("t2_level_4", sensor_level, 1);
        step(1);
        check("t2_hit", hit, 1);
        check("t2_count", hit_count, 2);
        step(10);

        // ---- already light at arm: no hit until dark is seen ----
        SENSOR = 1'b0;
        step(10);
        check("t3_light", sensor_level, 1);
        pulse_arm();
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            seen = seen | hit;
        end
        check("t3_no_hit", seen, 0);
        check("t3_waiting", waiting, 1);
        SENSOR = 1'b1;
        step(8);
        SENSOR = 1'b0;
        step(7);
        check("t3_hit", hit, 1);
        check("t3_count", hit_count, 3);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            seen = seen | hit;
        end
        check("t3_hit_once", seen, 0);

        // ---- timeout 100 cycles after arm ----
        SENSOR = 1'b1;
        step(10);
        pulse_arm();
        seen = 1'b0;
        for (int k = 0; k < 99; k++) begin
            step(1);
            seen = seen | timeout;
        end
        check("t4_no_early_timeout", seen, 0);
        step(1);
        check("t4_timeout", timeout, 1);
        check("t4_waiting", waiting, 0);
        check("t4_count", hit_count, 3);
        step(1);
        check("t4_timeout_single", timeout, 0);

        // ---- re-arm at cycle 50 restarts the window ----
        pulse_arm();
        step(49);
        pulse_arm();
        seen = 1'b0;
        for (int k = 0; k < 99; k++) begin
            step(1);
            seen = seen | timeout;
        end
        check("t5_no_old_timeout", seen, 0);
        step(1);
        check("t5_timeout", timeout, 1);

        // ---- arm coinciding with the hit cycle suppresses the hit ----
        step(2);
        pulse_arm();
        step(3);
        SENSOR = 1'b0;
        step(6);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        check("t5_arm_beats_hit", hit, 0);
        check("t5_rearm_waiting", waiting, 1);
        check("t5_count", hit_count, 3);
        step(5);
        check("t5_wait_dark_no_hit", hit, 0);
        check("t5_wait_dark", waiting, 1);

        // ---- asynchronous reset while armed ----
        SENSOR = 1'b1;
        step(10);
        reset = 1'b1;
        #1;
        check("t6_rst_waiting", waiting, 0);
        check("t6_rst_count", hit_count, 0);
        check("t6_rst_level", sensor_level, 0);
        check("t6_rst_hit", hit, 0);
        step(1);
        reset = 1'b0;
        step(10);
        SENSOR = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            seen = seen | hit | timeout | waiting;
        end
        check("t6_idle_no_activity", seen, 0);
        check("t6_idle_level", sensor_level, 1);

        // ---- 256 measurements wrap hit_count ----
        for (int i = 0; i < 256; i++) begin
            SENSOR = 1'b1;
            step(8);
            pulse_arm();
            step(2);
            SENSOR = 1'b0;
            step(8);
            if (i == 254) begin
                check("t7_count_255", hit_count, 255);
            end
        end
        check("t7_count_wrap", hit_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
